// File: rtl/rr_mux_arbiter_pkg.sv
// Shared types and constants for the round-robin arbiter with a registered 4:1 data mux.
// The optional lock feature is enabled by defining RR_MUX_ARBITER_LOCK_EN.
package rr_mux_arbiter_pkg;

    localparam int NUM_REQ = 4;
    localparam int SEL_W   = 2;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    typedef struct packed {
        logic             found;
        logic [SEL_W-1:0] idx;
    } pick_t;

    // First asserted request at or after ptr, wrapping modulo NUM_REQ.
    function automatic pick_t rr_pick(input logic [NUM_REQ-1:0] req,
                                      input logic [SEL_W-1:0]   ptr);
        pick_t            res;
        logic [SEL_W-1:0] idx;
        res = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            idx = ptr + SEL_W'(k);
            if (req[idx]) begin
                res.found = 1'b1;
                res.idx   = idx;
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/rr_mux_arbiter_if.sv
// Request/data/grant bundle between requesters (master) and the arbiter (slave).
interface rr_mux_arbiter_if;
    import rr_mux_arbiter_pkg::*;

    logic [NUM_REQ-1:0] req;
    logic [NUM_REQ-1:0] i;
    logic [NUM_REQ-1:0] gnt;
    logic [SEL_W-1:0]   s;
    logic               F;
    logic               busy;

    modport master (output req, i, input gnt, s, F, busy);
    modport slave  (input req, i, output gnt, s, F, busy);

endinterface

// File: rtl/mux_4x1.sv
// Plain combinational 4:1 bit mux.
module mux_4x1 (
    input  logic [3:0] i,
    input  logic [1:0] s,
    output logic       F
);

    assign F = i[s];

endmodule

// File: rtl/rr_mux_arbiter.sv
// Round-robin arbiter with bounded hold and a registered 4:1 data mux on the grant.
// Define RR_MUX_ARBITER_LOCK_EN to add the lock input that suppresses hold expiry.
module rr_mux_arbiter
    import rr_mux_arbiter_pkg::*;
#(
    parameter int MAX_HOLD = 4
) (
    input  logic clk,
    input  logic rst_n,
`ifdef RR_MUX_ARBITER_LOCK_EN
    input  logic lock,
`endif
    rr_mux_arbiter_if.slave bus
);

    localparam logic [3:0] HOLD_LAST = 4'(MAX_HOLD - 1);

    state_t           state;
    logic [SEL_W-1:0] ptr;
    logic [3:0]       hold_cnt;

    logic             mux_f;
    logic             lock_keep;
    logic             expired;
    logic             release_gnt;
    logic [SEL_W-1:0] search_ptr;
    pick_t            pick;
    logic             next_busy;

    mux_4x1 u_mux (
        .i (bus.i),
        .s (bus.s),
        .F (mux_f)
    );

    // NOTE: every signal gets a default at the top of always_comb so no path leaves it unassigned (no latch).
    always_comb begin
        lock_keep = 1'b0;
`ifdef RR_MUX_ARBITER_LOCK_EN
        lock_keep = lock & bus.req[bus.s];
`endif
        expired     = (hold_cnt >= HOLD_LAST) && !lock_keep;
        release_gnt = (state == GRANT) && (!bus.req[bus.s] || expired);
        // A releasing grant searches from owner+1 so the rearbitration uses the updated pointer.
        search_ptr  = release_gnt ? bus.s + SEL_W'(1) : ptr;
        pick        = rr_pick(bus.req, search_ptr);
        next_busy   = (state == GRANT && !release_gnt) ? 1'b1 : pick.found;
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            ptr      <= '0;
            hold_cnt <= '0;
            bus.gnt  <= '0;
            bus.s    <= '0;
            bus.F    <= 1'b0;
            bus.busy <= 1'b0;
        end else begin
            // F lags s by one cycle and is forced low in any cycle spent idle.
            bus.F <= mux_f & bus.busy & next_busy;

            case (state)
                IDLE: begin
                    if (pick.found) begin
                        state    <= GRANT;
                        bus.gnt  <= NUM_REQ'(1) << pick.idx;
                        bus.s    <= pick.idx;
                        bus.busy <= 1'b1;
                        hold_cnt <= '0;
                    end
                end

                GRANT: begin
                    if (release_gnt) begin
                        ptr <= search_ptr;
                        if (pick.found) begin
                            bus.gnt  <= NUM_REQ'(1) << pick.idx;
                            bus.s    <= pick.idx;
                            hold_cnt <= '0;
                        end else begin
                            state    <= IDLE;
                            bus.gnt  <= '0;
                            bus.busy <= 1'b0;
                            hold_cnt <= '0;
                        end
                    end else if (hold_cnt < HOLD_LAST) begin
                        // Saturates while locked so expiry fires right after the lock drops.
                        hold_cnt <= hold_cnt + 4'd1;
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rr_mux_arbiter.sv
// Directed self-checking bench for rr_mux_arbiter (MAX_HOLD=4).
// Lock scenario runs only when RR_MUX_ARBITER_LOCK_EN is defined.
module tb_rr_mux_arbiter;

    logic clk = 1'b0;
    logic rst_n;
`ifdef RR_MUX_ARBITER_LOCK_EN
    logic lock;
`endif

    int checks = 0;
    int errors = 0;

    rr_mux_arbiter_if bus ();

    rr_mux_arbiter #(.MAX_HOLD(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
`ifdef RR_MUX_ARBITER_LOCK_EN
        .lock  (lock),
`endif
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance one rising edge and settle 1 time unit past it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [3:0] exp_gnt;

        rst_n   = 1'b0;
        bus.req = 4'b1111;
        bus.i   = 4'b0000;
`ifdef RR_MUX_ARBITER_LOCK_EN
        lock    = 1'b0;
`endif
        tick();
        tick();
        check("rst_gnt",  32'(bus.gnt),  32'h0);
        check("rst_s",    32'(bus.s),    32'h0);
        check("rst_busy", 32'(bus.busy), 32'h0);
        check("rst_F",    32'(bus.F),    32'h0);

        // First edge after release: requester 0 wins.
        rst_n = 1'b1;
        tick();
        check("first_gnt",  32'(bus.gnt),  32'h1);
        check("first_s",    32'(bus.s),    32'h0);
        check("first_busy", 32'(bus.busy), 32'h1);

        // All requesting: rotate every 4 cycles, no idle bubble.
        for (int k = 2; k <= 17; k++) begin
            tick();
            exp_gnt = 4'b0001 << (((k - 1) / 4) % 4);
            check($sformatf("rot_gnt_%0d", k), 32'(bus.gnt), 32'(exp_gnt));
            check($sformatf("rot_busy_%0d", k), 32'(bus.busy), 32'h1);
        end

        // Reset mid-grant drops it at that edge.
        rst_n   = 1'b0;
        bus.req = 4'b0000;
        tick();
        check("midrst_gnt",  32'(bus.gnt),  32'h0);
        check("midrst_busy", 32'(bus.busy), 32'h0);
        rst_n = 1'b1;
        bus.i = 4'b0100;
        tick();
        check("idle_busy", 32'(bus.busy), 32'h0);

        // Requester 2 for two cycles, then idle with s held at 2.
        bus.req = 4'b0100;
        tick();
        check("r2_gnt_a", 32'(bus.gnt), 32'h4);
        check("r2_s",     32'(bus.s),   32'h2);
        check("r2_F_a",   32'(bus.F),   32'h0);
        tick();
        check("r2_gnt_b", 32'(bus.gnt), 32'h4);
        check("r2_F_b",   32'(bus.F),   32'h1);
        bus.req = 4'b0000;
        tick();
        check("r2_idle_gnt",  32'(bus.gnt),  32'h0);
        check("r2_idle_busy", 32'(bus.busy), 32'h0);
        check("r2_idle_s",    32'(bus.s),    32'h2);
        check("r2_idle_F",    32'(bus.F),    32'h0);

        // Requester 1 granted; F follows i[1] one cycle later.
        bus.req = 4'b0010;
        bus.i   = 4'b0000;
        tick();
        check("r1_gnt", 32'(bus.gnt), 32'h2);
        check("r1_s",   32'(bus.s),   32'h1);
        bus.i = 4'b0010;
        tick();
        check("r1_F_hi", 32'(bus.F), 32'h1);
        bus.i = 4'b1101;
        tick();
        check("r1_F_lo", 32'(bus.F), 32'h0);
        bus.i = 4'b0010;
        tick();
        check("r1_F_hi2", 32'(bus.F), 32'h1);
        bus.req = 4'b0000;
        bus.i   = 4'b0000;
        tick();
        check("r1_idle_busy", 32'(bus.busy), 32'h0);

        // Only requester 3: held continuously across expiry re-grants.
        bus.req = 4'b1000;
        for (int k = 1; k <= 10; k++) begin
            tick();
            check($sformatf("r3_gnt_%0d", k), 32'(bus.gnt), 32'h8);
            check($sformatf("r3_busy_%0d", k), 32'(bus.busy), 32'h1);
        end

        // Requester 0 arrives mid-grant: no preemption until expiry.
        bus.req = 4'b1001;
        tick();
        check("nopre_a", 32'(bus.gnt), 32'h8);
        tick();
        check("nopre_b", 32'(bus.gnt), 32'h8);
        tick();
        check("nopre_hand", 32'(bus.gnt), 32'h1);

`ifdef RR_MUX_ARBITER_LOCK_EN
        rst_n   = 1'b0;
        bus.req = 4'b0011;
        lock    = 1'b1;
        tick();
        rst_n = 1'b1;
        for (int k = 1; k <= 7; k++) begin
            tick();
            check($sformatf("lock_gnt_%0d", k), 32'(bus.gnt), 32'h1);
        end
        lock = 1'b0;
        tick();
        check("unlock_gnt", 32'(bus.gnt), 32'h2);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/rr_mux_arbiter.md
RR_MUX_ARBITER -- requirements
Module: rr_mux_arbiter

Interface
REQ-001 The block SHALL have parameter MAX_HOLD, default 4, giving the maximum consecutive cycles one grant is held (legal 1..15).
REQ-002 The block SHALL have port clk  input  1  rising-edge clock.
REQ-003 The block SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-004 The block SHALL have port req  input  4  per-requester request, bit k = requester k.
REQ-005 The block SHALL have port i  input  4  per-requester data bit, routed through a 4:1 mux.
REQ-006 The block SHALL have port gnt  output  4  registered one-hot grant, all-zero when idle.
REQ-007 The block SHALL have port s  output  2  registered mux select, equal to the granted index.
REQ-008 The block SHALL have port F  output  1  registered mux output.
REQ-009 The block SHALL have port busy  output  1  high while any grant is active.

Function
REQ-010 The FSM SHALL have two states: IDLE (gnt=0) and GRANT (exactly one gnt bit set).
REQ-011 Arbitration SHALL be round-robin: search starts at ptr and wraps modulo 4, and the first asserted req wins.
REQ-012 On leaving any grant, ptr SHALL be set to owner+1 mod 4.
REQ-013 In IDLE, when req is nonzero at edge N, gnt, s and busy SHALL reflect the winner after edge N (one-cycle latency).
REQ-014 In GRANT, hold_cnt SHALL increment each cycle; it is reset to 0 on every new grant.
REQ-015 A grant SHALL be released when req[owner] is low, or when hold_cnt reaches MAX_HOLD-1.
REQ-016 On release with other requests pending, the block SHALL rearbitrate on the same edge, with no idle bubble.
REQ-017 On release with no request pending, the block SHALL go to IDLE: gnt=0, busy=0, s holds its last value.
REQ-018 On expiry when only the owner requests, the block SHALL re-grant the owner with hold_cnt=0.
REQ-019 F SHALL equal the registered value of i[s] & busy, sampled one cycle after s; F SHALL be 0 in IDLE.
REQ-020 Requests arriving while a grant is active SHALL NOT preempt it.
REQ-021 Simultaneous requests SHALL be resolved solely by ptr order.

Reset
REQ-022 While rst_n=0 at a clock edge, the block SHALL set: state=IDLE, gnt=0, s=0, F=0, busy=0, ptr=0, hold_cnt=0.
REQ-023 Reset asserted mid-grant SHALL drop the grant at that edge, with no partial hold carried over.
REQ-024 req sampled on the first edge after reset release SHALL be arbitrated normally, with requester 0 highest priority.

Configuration
REQ-025 Macro RR_MUX_ARBITER_LOCK_EN, when defined, SHALL add an input port lock (1 bit).
REQ-026 With the macro defined, lock=1 together with req[owner]=1 SHALL suppress MAX_HOLD expiry; the owner keeps the grant.
REQ-027 Without the macro, the lock port SHALL NOT exist and MAX_HOLD expiry SHALL always apply.

Structure
REQ-028 A shared package rr_mux_arbiter_pkg SHALL hold the FSM state typedef (IDLE, GRANT), NUM_REQ=4 and SEL_W=2.
REQ-029 The datapath SHALL instantiate the existing mux_4x1 (ports i, s, F) as its single sub-module; the arbiter registers its output.

Verification
REQ-030 Reset with req=4'b1111, then release -> gnt=0001, s=0 one cycle later, busy=1.
REQ-031 req=4'b1111 held, MAX_HOLD=4 -> grants 0001,0010,0100,1000,0001 rotate every 4 cycles, with no idle cycle.
REQ-032 req=4'b0100 for 2 cycles then 0 -> gnt=0100 for 2 cycles, then IDLE with gnt=0, busy=0, s=2, F=0.
REQ-033 Grant on requester 1, i=4'b0010 then i=4'b1101 -> F=1 then F=0, each one cycle after i changes.
REQ-034 Only req[3] held for 10 cycles -> gnt=1000 continuously, with hold_cnt wrapping at 3 (re-grant).
REQ-035 With RR_MUX_ARBITER_LOCK_EN: lock=1, req=4'b0011, owner 0 -> gnt=0001 beyond 4 cycles; after lock=0, gnt moves to 0010 after expiry.
